calc_entry_engine: RTL and testbench
====================================

Name: calc_entry_engine

Overview:
- Consumes the decoded keypad event stream: digit code plus `numPressed`, operator code plus `optPressed`, and `submit`.
- Assembles two decimal operands and one operator, then computes the result when submit is pressed.
- Sits between the keypad decoder and the display/tone back-end.
- Add, subtract and multiply complete in one cycle. Divide and modulo run on a sequential divider.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits per operand; further digits are ignored.
- W, 16, operand/result datapath width; must hold 10^MAX_DIGITS - 1.
- DIV_W, 16, divider width; equals W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- num  in  4  digit code; valid while numPressed=1.
- numPressed  in  1  level, high while a digit key is held.
- opt  in  3  operator code; 1=add, 2=sub, 3=mul, 4=div, 5=mod; valid while optPressed=1.
- optPressed  in  1  level, high while an operator key is held.
- submit  in  1  level, high while the submit key is held.
- disp_val  out  W  value to display: current entry, or result in DONE.
- disp_op  out  3  stored operator, 0 if none.
- neg  out  1  result is negative; disp_val holds the magnitude.
- err  out  1  overflow (result > 10^MAX_DIGITS - 1) or division by zero.
- busy  out  1  divider running.
- result_valid  out  1  one-cycle pulse when a result is committed.

Behaviour:
- Reset values:
  - state=ENTER_A; acc_a=0, acc_b=0, digit count=0, op=0.
  - All outputs 0.
- Edge detection:
  - Register each of numPressed/optPressed/submit and act only on its 0->1 edge.
  - A held key produces exactly one event.
  - If more than one edge occurs in the same cycle, priority is submit > operator > digit; the lower-priority edges are dropped.
- Digit event (num <= 9; num > 9 is ignored):
  - entry = entry*10 + num when count < MAX_DIGITS, then count++.
  - Otherwise ignored; the value is unchanged.
- States:
  - ENTER_A:
    - Digit edits acc_a; disp_val=acc_a.
    - Operator with code 1..5: op<=opt, go OP_WAIT. Code 0, 6 or 7 is ignored.
    - Submit is ignored.
  - OP_WAIT:
    - Operator replaces op.
    - Digit: acc_b=num, count=1, go ENTER_B.
    - Submit is ignored; disp_val=acc_a.
  - ENTER_B:
    - Digit edits acc_b; disp_val=acc_b.
    - Operator is ignored.
    - Submit with op in 1..3: compute, go DONE on the next edge; result_valid pulses in that same cycle.
    - Submit with op in 4..5:
      - acc_b=0: err=1, go DONE, result_valid pulses.
      - Otherwise: assert div start, go DIV, busy=1.
  - DIV:
    - All key edges are ignored.
    - Wait for div done, exactly DIV_W cycles after start.
    - Then latch the quotient (op 4) or remainder (op 5), go DONE, result_valid pulses, busy=0.
    - Submit-to-result_valid = DIV_W + 2 cycles.
  - DONE:
    - disp_val=result, with neg/err valid.
    - Operator with err=0 and neg=0: acc_a<=result, op<=opt, count=MAX_DIGITS (chained entry is locked), go OP_WAIT.
    - Operator with err=1 or neg=1: ignored.
    - Digit: clear neg/err/op/acc_b, acc_a=num, count=1, go ENTER_A.
    - Submit is ignored.
- Arithmetic:
  - Add: W+1-bit sum; err if the sum exceeds the max value.
  - Sub: if a >= b, result=a-b; otherwise neg=1 and result=b-a.
  - Mul: 2W-bit product; err if it exceeds the max value. On err, disp_val=0.
  - Div/mod: unsigned.
  - neg and err hold until the next digit edge in DONE or a reset.
- Reset mid-division: the divider aborts, busy drops on the next edge, and no result_valid is produced.

Decomposition:
- Shared package calc_pkg:
  - Operator codes OP_NONE/ADD/SUB/MUL/DIV/MOD.
  - State enum ENTER_A/OP_WAIT/ENTER_B/DIV/DONE.
  - MAX_VAL constant.
- Sub-module seq_divider:
  - Restoring, one quotient bit per cycle, 16-bit.
  - Ports: clk, reset, start, dividend, divisor, busy, done (1-cycle pulse), quotient, remainder.
  - start is ignored while busy.

Test Plan:
- Digits 1,2; op 1; digits 3,4; submit:
  - result_valid 1 cycle after the submit edge.
  - disp_val=46, neg=0, err=0.
- Digits 5; op 2; digit 9; submit -> disp_val=4, neg=1. Then op 1 is ignored (state stays DONE). Then digit 3 -> neg=0, disp_val=3.
- 9999 op 3 9999 submit -> err=1, disp_val=0. Entering a 5th digit '8' after 9999 leaves the operand at 9999.
- 100 op 4 7 submit:
  - busy=1 for 16 cycles.
  - result_valid at submit+18, disp_val=14.
  - Repeat with op 5 -> disp_val=2.
  - Key edges during busy are ignored.
- 12 op 4 0 submit -> err=1 with no busy period. Hold submit high for 50 cycles -> exactly one result_valid.
- Assert reset 5 cycles into a division:
  - Next cycle: busy=0, disp_val=0, state ENTER_A.
  - No result_valid.
  - Subsequent 7 op 1 8 submit -> 15.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared operator codes, FSM state encoding and decimal limits for the calculator entry path.
// No logic of its own; imported by the engine and used by the bench for its limits.
// No flow control; constants and a constant-evaluable helper only.
package calc_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;

    typedef enum logic [2:0] {
        ENTER_A,
        OP_WAIT,
        ENTER_B,
        DIV,
        DONE
    } state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int unsigned DEF_MAX_DIGITS = 4;
    localparam int unsigned MAX_VAL        = pow10(DEF_MAX_DIGITS) - 1;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle.
// Latency: done pulses W cycles after an accepted start; busy is high for exactly those W cycles.
// Backpressure: none; start while busy is dropped, the caller must wait for done.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(W);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W:0] shifted;
    logic [W:0] diff;

    // The partial remainder is always below the divisor, so the trial
    // difference fits back into W bits whenever it does not borrow.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        if (busy_q) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            busy_d = 1'b1;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/calc_entry_engine.sv
// Keypad-driven calculator: builds two decimal operands and an operator, then evaluates on submit.
// Latency: add/sub/mul result one cycle after the submit edge; div/mod DIV_W + 2 cycles.
// Backpressure: none; key edges that arrive while the divider runs are discarded.
module calc_entry_engine
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int W          = 16,
    parameter int DIV_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   num,
    input  logic         numPressed,
    input  logic [2:0]   opt,
    input  logic         optPressed,
    input  logic         submit,
    output logic [W-1:0] disp_val,
    output logic [2:0]   disp_op,
    output logic         neg,
    output logic         err,
    output logic         busy,
    output logic         result_valid
);

    localparam int unsigned  MAX_V = pow10(MAX_DIGITS) - 1;
    localparam int           CW    = $clog2(MAX_DIGITS + 1);
    localparam logic [W-1:0] MAX_W = W'(MAX_V);
    localparam logic [W-1:0] TEN   = W'(10);

    state_t        state_q, state_d;
    logic [W-1:0]  acc_a_q, acc_a_d;
    logic [W-1:0]  acc_b_q, acc_b_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;
    logic          rv_q, rv_d;
    logic          num_prev_q, opt_prev_q, sub_prev_q;

    logic          sub_ev, opt_ev, dig_ev;
    logic          div_start, div_busy, div_done;
    logic [W-1:0]  div_quo, div_rem;
    logic [W-1:0]  digit_w;
    logic [W:0]    sum;
    logic [2*W-1:0] prod;
    logic [W-1:0]  alu_res;
    logic          alu_neg, alu_err;
    logic          can_digit;

    // One event per key press; submit outranks operator outranks digit.
    assign sub_ev  = submit & ~sub_prev_q;
    assign opt_ev  = optPressed & ~opt_prev_q & ~sub_ev
                   & (opt >= OP_ADD) & (opt <= OP_MOD);
    assign dig_ev  = numPressed & ~num_prev_q & ~sub_ev & ~(optPressed & ~opt_prev_q)
                   & (num <= 4'd9);
    assign digit_w = W'(num);
    assign can_digit = (cnt_q < CW'(MAX_DIGITS));

    assign sum  = {1'b0, acc_a_q} + {1'b0, acc_b_q};
    assign prod = {{W{1'b0}}, acc_a_q} * {{W{1'b0}}, acc_b_q};

    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_err = (sum > {1'b0, MAX_W});
                alu_res = alu_err ? '0 : sum[W-1:0];
            end
            OP_SUB: begin
                alu_neg = (acc_a_q < acc_b_q);
                alu_res = alu_neg ? (acc_b_q - acc_a_q) : (acc_a_q - acc_b_q);
            end
            OP_MUL: begin
                alu_err = (prod > {{W{1'b0}}, MAX_W});
                alu_res = alu_err ? '0 : prod[W-1:0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        err_d     = err_q;
        rv_d      = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (dig_ev && can_digit) begin
                    acc_a_d = acc_a_q * TEN + digit_w;
                    cnt_d   = cnt_q + CW'(1);
                end else if (opt_ev) begin
                    op_d    = opt;
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (opt_ev) begin
                    op_d = opt;
                end else if (dig_ev) begin
                    acc_b_d = digit_w;
                    cnt_d   = CW'(1);
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                if (sub_ev) begin
                    if (op_q == OP_DIV || op_q == OP_MOD) begin
                        if (acc_b_q == '0) begin
                            err_d   = 1'b1;
                            res_d   = '0;
                            rv_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = DIV;
                        end
                    end else begin
                        res_d   = alu_res;
                        neg_d   = alu_neg;
                        err_d   = alu_err;
                        rv_d    = 1'b1;
                        state_d = DONE;
                    end
                end else if (dig_ev && can_digit) begin
                    acc_b_d = acc_b_q * TEN + digit_w;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DIV: begin
                if (div_done) begin
                    res_d   = (op_q == OP_DIV) ? div_quo : div_rem;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A signed or overflowed result cannot seed a chained operation.
                if (opt_ev && !err_q && !neg_q) begin
                    acc_a_d = res_q;
                    op_d    = opt;
                    cnt_d   = CW'(MAX_DIGITS);
                    state_d = OP_WAIT;
                end else if (dig_ev) begin
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    op_d    = OP_NONE;
                    acc_b_d = '0;
                    acc_a_d = digit_w;
                    cnt_d   = CW'(1);
                    state_d = ENTER_A;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ENTER_A;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            op_q       <= OP_NONE;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            rv_q       <= 1'b0;
            num_prev_q <= 1'b0;
            opt_prev_q <= 1'b0;
            sub_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            rv_q       <= rv_d;
            num_prev_q <= numPressed;
            opt_prev_q <= optPressed;
            sub_prev_q <= submit;
        end
    end

    seq_divider #(
        .W(DIV_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (acc_a_q),
        .divisor   (acc_b_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        case (state_q)
            ENTER_A, OP_WAIT: disp_val = acc_a_q;
            ENTER_B, DIV:     disp_val = acc_b_q;
            DONE:             disp_val = res_q;
            default:          disp_val = '0;
        endcase
    end

    assign disp_op      = op_q;
    assign neg          = neg_q;
    assign err          = err_q;
    assign busy         = div_busy;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_entry_engine.sv
// Directed bench for calc_entry_engine: an integer-level calculator model is checked every
// cycle, and literal expectations from hand-worked key sequences pin that model.
module tb_calc_entry_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  num = '0;
    logic        numPressed = 1'b0;
    logic [2:0]  opt = '0;
    logic        optPressed = 1'b0;
    logic        submit = 1'b0;
    logic [15:0] disp_val;
    logic [2:0]  disp_op;
    logic        neg, err, busy, result_valid;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    calc_entry_engine dut (
        .clk          (clk),
        .reset        (reset),
        .num          (num),
        .numPressed   (numPressed),
        .opt          (opt),
        .optPressed   (optPressed),
        .submit       (submit),
        .disp_val     (disp_val),
        .disp_op      (disp_op),
        .neg          (neg),
        .err          (err),
        .busy         (busy),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Calculator model: phases 0=first operand, 1=operator chosen, 2=second operand,
    // 3=dividing, 4=showing result.
    int m_ph, m_a, m_b, m_na, m_nb, m_op, m_res, m_ng, m_er, m_rv, m_left;
    bit p_n, p_o, p_s;
    bit e_n, e_o, e_s;
    int r;
    localparam int LIMIT = calc_pkg::MAX_VAL;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
            m_res = 0; m_ng = 0; m_er = 0; m_rv = 0; m_left = 0;
            p_n = 0; p_o = 0; p_s = 0;
        end else begin
            e_s = submit && !p_s;
            e_o = optPressed && !p_o && !e_s;
            e_n = numPressed && !p_n && !e_s && !(optPressed && !p_o);
            p_n = numPressed; p_o = optPressed; p_s = submit;
            m_rv = 0;
            if (m_ph == 3) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = (m_op == 4) ? (m_a / m_b) : (m_a % m_b);
                    m_ph = 4;
                    m_rv = 1;
                end
            end else if (e_s) begin
                if (m_ph == 2) begin
                    if (m_op <= 3) begin
                        if (m_op == 1) r = m_a + m_b;
                        else if (m_op == 2) r = (m_a >= m_b) ? m_a - m_b : m_b - m_a;
                        else r = m_a * m_b;
                        m_ng = (m_op == 2 && m_a < m_b) ? 1 : 0;
                        m_er = (r > LIMIT) ? 1 : 0;
                        m_res = m_er ? 0 : r;
                        m_ph = 4;
                        m_rv = 1;
                    end else if (m_b == 0) begin
                        m_er = 1; m_res = 0; m_ph = 4; m_rv = 1;
                    end else begin
                        m_ph = 3;
                        m_left = 17;
                    end
                end
            end else if (e_o) begin
                if (opt >= 1 && opt <= 5) begin
                    if (m_ph == 0 || m_ph == 1) begin
                        m_op = opt; m_ph = 1;
                    end else if (m_ph == 4 && !m_er && !m_ng) begin
                        m_a = m_res; m_op = opt; m_na = 4; m_ph = 1;
                    end
                end
            end else if (e_n && num <= 9) begin
                if (m_ph == 0) begin
                    if (m_na < 4) begin m_a = m_a * 10 + num; m_na++; end
                end else if (m_ph == 1) begin
                    m_b = num; m_nb = 1; m_ph = 2;
                end else if (m_ph == 2) begin
                    if (m_nb < 4) begin m_b = m_b * 10 + num; m_nb++; end
                end else if (m_ph == 4) begin
                    m_ng = 0; m_er = 0; m_op = 0; m_b = 0; m_a = num; m_na = 1; m_ph = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_disp_val", disp_val,
                (m_ph <= 1) ? m_a : (m_ph <= 3) ? m_b : m_res);
            chk("model_disp_op", disp_op, m_op);
            chk("model_neg", neg, m_ng);
            chk("model_err", err, m_er);
            chk("model_busy", busy, (m_ph == 3 && m_left >= 2) ? 1 : 0);
            chk("model_result_valid", result_valid, m_rv);
        end
    end

    task automatic digit(input int d);
        @(posedge clk); #2 num = 4'(d); numPressed = 1'b1;
        @(posedge clk); #2 numPressed = 1'b0;
    endtask

    task automatic oper(input int o);
        @(posedge clk); #2 opt = 3'(o); optPressed = 1'b1;
        @(posedge clk); #2 optPressed = 1'b0;
    endtask

    task automatic enter(input int v);
        int ds[$];
        int x;
        x = v;
        do begin ds.push_front(x % 10); x = x / 10; end while (x != 0);
        foreach (ds[i]) digit(ds[i]);
    endtask

    // Raises submit, counts edges to result_valid and busy cycles; optional key noise.
    task automatic run_submit(input bit noise, output int lat, output int bc);
        int l;
        int b;
        l = 0;
        b = 0;
        @(posedge clk); #2 submit = 1'b1;
        forever begin
            @(posedge clk); #1;
            l++;
            if (busy) b++;
            if (result_valid) break;
            if (l >= 40) begin
                chk("submit_timeout", 0, 1);
                break;
            end
            #1;
            if (noise) begin
                num = 4'd5;
                opt = 3'd1;
                numPressed = l[0];
                optPressed = ~l[0];
            end
        end
        #1 submit = 1'b0; numPressed = 1'b0; optPressed = 1'b0;
        lat = l;
        bc = b;
    endtask

    initial begin
        int lat, bc, rvc, bsy;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_disp_val", disp_val, 0);
        chk("reset_disp_op", disp_op, 0);
        chk("reset_flags", {neg, err, busy, result_valid}, 0);
        chk_on = 1'b1;
        #1 reset = 1'b0;

        // 12 + 34
        enter(12); oper(1); enter(34);
        run_submit(0, lat, bc);
        chk("add_latency", lat, 1);
        chk("add_value", disp_val, 46);
        chk("add_flags", {neg, err}, 0);

        // 5 - 9, then a refused chained operator, then a fresh digit
        digit(5); oper(2); digit(9);
        run_submit(0, lat, bc);
        chk("sub_value", disp_val, 4);
        chk("sub_neg", neg, 1);
        oper(1);
        chk("neg_chain_ignored_op", disp_op, 2);
        chk("neg_chain_ignored_val", disp_val, 4);
        digit(3);
        chk("clear_neg", neg, 0);
        chk("clear_val", disp_val, 3);

        // 9999 * 9999 with a fifth digit that must be dropped
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        enter(9999); digit(8);
        chk("five_digit_clamp", disp_val, 9999);
        oper(3); enter(9999);
        run_submit(0, lat, bc);
        chk("mul_err", err, 1);
        chk("mul_err_disp", disp_val, 0);

        // 100 / 7 with key noise while the divider runs, then 100 % 7
        enter(100); oper(4); digit(7);
        run_submit(1, lat, bc);
        chk("div_latency", lat, 18);
        chk("div_busy_cycles", bc, 16);
        chk("div_value", disp_val, 14);
        enter(100); oper(5); digit(7);
        run_submit(0, lat, bc);
        chk("mod_latency", lat, 18);
        chk("mod_value", disp_val, 2);

        // Chained: 2 + 3
        oper(1);
        chk("chain_op", disp_op, 1);
        chk("chain_disp", disp_val, 2);
        digit(3);
        run_submit(0, lat, bc);
        chk("chain_value", disp_val, 5);

        // 12 / 0 with submit held for 50 cycles
        enter(12); oper(4); digit(0);
        @(posedge clk); #2 submit = 1'b1;
        rvc = 0;
        bsy = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (result_valid) rvc++;
            if (busy) bsy++;
        end
        #1 submit = 1'b0;
        chk("div0_rv_count", rvc, 1);
        chk("div0_busy_cycles", bsy, 0);
        chk("div0_err", err, 1);

        // Reset five cycles into a division
        enter(100); oper(4); digit(7);
        @(posedge clk); #2 submit = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("mid_div_busy", busy, 1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_disp", disp_val, 0);
        chk("abort_op", disp_op, 0);
        #1 reset = 1'b0; submit = 1'b0;
        rvc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (result_valid) rvc++;
        end
        chk("abort_no_rv", rvc, 0);
        digit(7); oper(1); digit(8);
        run_submit(0, lat, bc);
        chk("post_reset_latency", lat, 1);
        chk("post_reset_value", disp_val, 15);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
